// File: rtl/brresolve_pkg.sv
// brresolve_pkg: shared types and constants for the EX-stage branch resolver.
package brresolve_pkg;
  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} br_state_e;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  localparam logic [1:0] BHT_INIT = 2'b01;
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    return up ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/bht.sv
// bht: table of 2-bit saturating counters, combinational read, read-before-write update.
module bht
  import brresolve_pkg::*;
#(
  parameter int index_width = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [index_width-1:0] rd_idx,
  output logic                   rd_taken,
  input  logic                   wr_en,
  input  logic [index_width-1:0] wr_idx,
  input  logic                   wr_taken
);
  logic [1:0] ctr [2**index_width];
  assign rd_taken = ctr[rd_idx][1];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2**index_width; i++) ctr[i] <= BHT_INIT;
    else if (wr_en) ctr[wr_idx] <= sat_step(ctr[wr_idx], wr_taken);
endmodule

// File: rtl/brresolve.sv
// brresolve: resolves EX branches/jumps against the IF prediction, trains the BHT, sequences redirect/flush.
module brresolve
  import brresolve_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int index_width = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [data_width-1:0] if_pc_i,
  output logic                  if_pred_taken_o,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_br_i,
  input  logic                  ex_is_jmp_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [data_width-1:0] ex_pc_i,
  input  logic [data_width-1:0] ex_target_i,
  input  logic                  ex_pred_taken_i,
  input  logic [data_width-1:0] ex_pred_target_i,
  output logic                  br_unsigned_o,
  input  logic                  br_less_i,
  input  logic                  br_equal_i,
  output logic                  redirect_o,
  output logic [data_width-1:0] redirect_pc_o,
  output logic                  flush_o,
  output logic [31:0]           br_cnt_o,
  output logic [31:0]           mispred_cnt_o
);
  br_state_e state, state_n;
  logic active, cbr, cond_taken, taken, resolve, mispred;
  logic [data_width-1:0] next_pc;
  assign br_unsigned_o = ex_funct3_i[1];
  assign active = ex_valid_i && state == IDLE;
  // a set jump flag wins over the branch flag; 010/011 are not branches
  assign cbr = ex_is_br_i && !ex_is_jmp_i && ex_funct3_i inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
  assign cond_taken = (ex_funct3_i == BEQ) ? br_equal_i :
                      (ex_funct3_i == BNE) ? !br_equal_i :
                      (ex_funct3_i == BLT || ex_funct3_i == BLTU) ? br_less_i : !br_less_i;
  assign taken = ex_is_jmp_i || (cbr && cond_taken);
  assign resolve = active && (ex_is_jmp_i || cbr);
  assign next_pc = taken ? ex_target_i : ex_pc_i + data_width'(4);
  assign mispred = resolve && (taken != ex_pred_taken_i || (taken && ex_pred_target_i != ex_target_i));
  bht #(.index_width(index_width)) u_bht (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_idx   (if_pc_i[index_width+1:2]),
    .rd_taken (if_pred_taken_o),
    .wr_en    (active && cbr),
    .wr_idx   (ex_pc_i[index_width+1:2]),
    .wr_taken (cond_taken)
  );
  always_comb begin
    state_n = (state == REDIRECT) ? SQUASH : (state == IDLE && mispred) ? REDIRECT : IDLE;
    redirect_o = state == REDIRECT;
    flush_o = state != IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      redirect_pc_o <= '0;
      br_cnt_o <= '0;
      mispred_cnt_o <= '0;
    end else begin
      state <= state_n;
      if (mispred) redirect_pc_o <= next_pc;
      if (resolve) br_cnt_o <= br_cnt_o + 32'd1;
      if (mispred) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
endmodule

// File: tb/tb_brresolve.sv
// tb_brresolve: table vectors, reset corner cases and randomized traffic against a behavioural model.
module tb_brresolve;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] if_pc_i, ex_pc_i, ex_target_i, ex_pred_target_i;
  logic if_pred_taken_o, ex_valid_i, ex_is_br_i, ex_is_jmp_i, ex_pred_taken_i;
  logic [2:0] ex_funct3_i;
  logic br_unsigned_o, br_less_i, br_equal_i, redirect_o, flush_o;
  logic [31:0] redirect_pc_o, br_cnt_o, mispred_cnt_o;

  brresolve dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i), .if_pred_taken_o(if_pred_taken_o),
    .ex_valid_i(ex_valid_i), .ex_is_br_i(ex_is_br_i), .ex_is_jmp_i(ex_is_jmp_i),
    .ex_funct3_i(ex_funct3_i), .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .br_unsigned_o(br_unsigned_o), .br_less_i(br_less_i), .br_equal_i(br_equal_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic v, br, jmp; logic [2:0] f3; logic [31:0] pc, tgt; logic pt; logic [31:0] ptgt;
    logic lt, eq; logic [31:0] ifpc;
    logic e_pred, e_uns, e_red, e_fl; logic [31:0] e_rpc, e_bc, e_mc;
  } vec_t;

  int tests = 0, fails = 0;
  int mctr [64];
  int busy;
  logic [31:0] mrpc, mbc, mmc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mctr[i]) mctr[i] = 1;
    busy = 0; mrpc = 0; mbc = 0; mmc = 0;
  endtask

  function automatic logic outcome(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic cycle(input vec_t t, input bit tab);
    logic tk;
    logic [31:0] npc;
    int k;
    if_pc_i = t.ifpc; ex_valid_i = t.v; ex_is_br_i = t.br; ex_is_jmp_i = t.jmp;
    ex_funct3_i = t.f3; ex_pc_i = t.pc; ex_target_i = t.tgt; ex_pred_taken_i = t.pt;
    ex_pred_target_i = t.ptgt; br_less_i = t.lt; br_equal_i = t.eq;
    #1;
    chk("pred", if_pred_taken_o, mctr[(t.ifpc >> 2) % 64] >= 2);
    chk("unsigned", br_unsigned_o, t.f3[1]);
    if (tab) begin
      chk("tab_pred", if_pred_taken_o, t.e_pred);
      chk("tab_unsigned", br_unsigned_o, t.e_uns);
    end
    if (busy > 0) busy--;
    else if (t.v && (t.jmp || (t.br && t.f3 != 3'd2 && t.f3 != 3'd3))) begin
      tk = t.jmp ? 1'b1 : outcome(t.f3, t.lt, t.eq);
      npc = tk ? t.tgt : t.pc + 32'd4;
      mbc++;
      if (tk != t.pt || (tk && t.ptgt != t.tgt)) begin
        mmc++; mrpc = npc; busy = 2;
      end
      if (!t.jmp) begin
        k = (t.pc >> 2) % 64;
        mctr[k] = tk ? (mctr[k] < 3 ? mctr[k] + 1 : 3) : (mctr[k] > 0 ? mctr[k] - 1 : 0);
      end
    end
    @(posedge clk_i);
    #1;
    chk("redirect", redirect_o, busy == 2);
    chk("flush", flush_o, busy > 0);
    chk("redirect_pc", redirect_pc_o, mrpc);
    chk("br_cnt", br_cnt_o, mbc);
    chk("mispred_cnt", mispred_cnt_o, mmc);
    if (tab) begin
      chk("tab_redirect", redirect_o, t.e_red);
      chk("tab_flush", flush_o, t.e_fl);
      chk("tab_redirect_pc", redirect_pc_o, t.e_rpc);
      chk("tab_br_cnt", br_cnt_o, t.e_bc);
      chk("tab_mispred_cnt", mispred_cnt_o, t.e_mc);
    end
  endtask

  vec_t tab [23];
  vec_t r;
  logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    tab[0]  = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h40,         0,0,0,0,32'h0,0,0};
    tab[1]  = '{1,1,0,0,32'h100,32'h120,0,32'h104,0,1,32'h100,   0,0,1,1,32'h120,1,1};
    tab[2]  = '{1,1,0,0,32'h100,32'h120,0,32'h104,0,1,32'h100,   1,0,0,1,32'h120,1,1};
    tab[3]  = '{1,1,0,1,32'h300,32'h340,0,32'h304,0,0,32'h300,   1,0,0,0,32'h120,1,1};
    tab[4]  = '{1,1,0,0,32'h100,32'h120,1,32'h120,0,1,32'h100,   1,0,0,0,32'h120,2,1};
    tab[5]  = '{1,1,0,0,32'h100,32'h120,1,32'h120,0,1,32'h100,   1,0,0,0,32'h120,3,1};
    tab[6]  = '{1,1,0,0,32'h100,32'h120,1,32'h120,0,0,32'h100,   1,0,1,1,32'h104,4,2};
    tab[7]  = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h100,         1,0,0,1,32'h104,4,2};
    tab[8]  = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h100,         1,0,0,0,32'h104,4,2};
    tab[9]  = '{1,1,0,6,32'h140,32'h180,0,32'h144,0,0,32'h140,   0,1,0,0,32'h104,5,2};
    tab[10] = '{1,1,0,1,32'h1F0,32'h204,1,32'h200,0,0,32'h1F0,   0,0,1,1,32'h204,6,3};
    tab[11] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h1F0,         1,0,0,1,32'h204,6,3};
    tab[12] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h140,         0,0,0,0,32'h204,6,3};
    tab[13] = '{1,0,1,0,32'h400,32'h800,0,32'h404,0,0,32'h400,   1,0,1,1,32'h800,7,4};
    tab[14] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h400,         1,0,0,1,32'h800,7,4};
    tab[15] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h400,         1,0,0,0,32'h800,7,4};
    tab[16] = '{1,1,0,5,32'hFFFFFFFC,32'h10,1,32'h10,1,0,32'hFFFFFFFC, 0,0,1,1,32'h0,8,5};
    tab[17] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'hFFFFFFFC,    0,0,0,1,32'h0,8,5};
    tab[18] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'hFFFFFFFC,    0,0,0,0,32'h0,8,5};
    tab[19] = '{1,1,1,2,32'h500,32'h900,1,32'h900,0,0,32'h500,   1,1,0,0,32'h0,9,5};
    tab[20] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h500,         1,0,0,0,32'h0,9,5};
    tab[21] = '{1,1,0,3,32'h600,32'h700,0,32'h604,1,1,32'h600,   1,1,0,0,32'h0,9,5};
    tab[22] = '{0,0,0,0,32'h0,32'h0,0,32'h0,0,0,32'h600,         1,0,0,0,32'h0,9,5};
    model_reset();
    if_pc_i = 32'h40; ex_valid_i = 0; ex_is_br_i = 0; ex_is_jmp_i = 0; ex_funct3_i = 3'd6;
    ex_pc_i = 0; ex_target_i = 0; ex_pred_taken_i = 0; ex_pred_target_i = 0;
    br_less_i = 0; br_equal_i = 0;
    #1;
    chk("rst_pred", if_pred_taken_o, 0);
    chk("rst_unsigned", br_unsigned_o, 1);
    chk("rst_redirect", redirect_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_redirect_pc", redirect_pc_o, 0);
    chk("rst_counts", br_cnt_o | mispred_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    for (int i = 0; i < 23; i++) cycle(tab[i], 1'b1);

    // asynchronous reset while a redirect is in flight
    r = tab[1];
    cycle(r, 1'b0);
    chk("pre_rst_redirect", redirect_o, 1);
    rst_i = 1;
    #1;
    chk("async_redirect", redirect_o, 0);
    chk("async_flush", flush_o, 0);
    chk("async_redirect_pc", redirect_pc_o, 0);
    chk("async_br_cnt", br_cnt_o, 0);
    chk("async_mispred_cnt", mispred_cnt_o, 0);
    chk("async_bht", if_pred_taken_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    r = tab[0];
    cycle(r, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = tab[0];
      r.v = $urandom_range(0, 3) != 0;
      r.jmp = $urandom_range(0, 4) == 0;
      r.br = $urandom_range(0, 5) != 0;
      r.f3 = f3s[$urandom_range(0, 5)];
      r.pc = 32'($urandom_range(0, 255)) << 2;
      r.tgt = $urandom & 32'hFFFFFFFC;
      r.pt = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: r.ptgt = r.tgt;
        1: r.ptgt = r.pc + 32'd4;
        default: r.ptgt = $urandom & 32'hFFFFFFFC;
      endcase
      r.lt = $urandom_range(0, 1) == 1;
      r.eq = $urandom_range(0, 1) == 1;
      r.ifpc = $urandom_range(0, 1) == 1 ? r.pc : 32'($urandom_range(0, 255)) << 2;
      cycle(r, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
